vram_arbiter: RTL and testbench
===============================

Name: vram_arbiter

Overview:
- Shares the single-port 8 KB video RAM (4 KB character/attribute data at 0x0000–0x0FFF, 4 KB 8x16 font at 0x1000–0x1FFF) between two masters.
- Display fetch port: absolute priority, fixed latency, never stalled.
- CPU port: req/ack handshake; writes into the font region can be blocked.
- Sits between the text-mode video generator, the CPU bus bridge and the RAM macro. RAM is synchronous, 1-cycle read latency, accepts a new address every cycle.

Parameters:
- AW, 13, RAM address width in bits.
- FONT_BASE, 13'h1000, first font address; lower bound of the write-protected region.
- MAX_WAIT, 64, CPU wait cycles after which cpu_starve asserts; saturating.

Ports:
- clock_25  in  1  pixel clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- disp_req  in  1  display read request; single-cycle, may repeat every cycle.
- disp_addr  in  AW  display read address, sampled with disp_req.
- disp_data  out  8  display read data.
- disp_valid  out  1  one-cycle strobe, disp_data valid.
- cpu_req  in  1  CPU request; held high until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req is high.
- cpu_addr  in  AW  CPU address; stable while cpu_req is high.
- cpu_wdata  in  8  CPU write data.
- cpu_rdata  out  8  CPU read data, valid with cpu_ack on reads.
- cpu_ack  out  1  one-cycle completion strobe.
- font_wp  in  1  1 = CPU writes at or above FONT_BASE are discarded.
- cpu_starve  out  1  wait counter reached MAX_WAIT.
- mem_addr  out  AW  RAM address, registered.
- mem_we  out  1  RAM write enable, registered.
- mem_wdata  out  8  RAM write data, registered.
- mem_rdata  in  8  RAM read data, valid one cycle after address.

Behaviour:
Reset:
- All outputs 0: mem_*, disp_*, cpu_ack, cpu_rdata, cpu_starve.
- Pipeline tags cleared, cpu_busy = 0, wait counter = 0.
- In-flight operations are dropped; no ack or valid is produced for them after reset.

Arbitration, evaluated at each edge:
- disp_req = 1: issue a display read (mem_addr <= disp_addr, mem_we <= 0). This happens regardless of CPU state.
- Otherwise, if cpu_req = 1, cpu_busy = 0 and cpu_ack is not asserted this cycle: grant the CPU and set cpu_busy.
- Otherwise: mem_we <= 0. mem_addr holds its value.

Tag pipeline:
- Two stages, t1 and t2, each {valid, src: DISP / CPU_RD / CPU_WR}, advancing every cycle.
- Display and CPU operations interleave freely.

Display path:
- disp_req sampled at edge E0 -> mem_addr at E0 -> RAM samples at E1 -> disp_data <= mem_rdata and disp_valid = 1 at E2.
- Latency is exactly 2 cycles, every time. Back-to-back requests give back-to-back strobes.

CPU read:
- Granted at E0. cpu_rdata <= mem_rdata and cpu_ack = 1 at E2. cpu_busy clears at E2.

CPU write:
- Granted at E0: mem_we <= 1, mem_wdata <= cpu_wdata for exactly one cycle.
- cpu_ack = 1 at E1. cpu_busy clears at E1.

Write protect:
- If font_wp = 1 and cpu_addr >= FONT_BASE at grant: mem_we stays 0 and RAM is unchanged.
- The cycle is still consumed and ack is still given at E1.

Handshake rules:
- cpu_req high in the cycle after cpu_ack is a new request.
- The arbiter never grants in the same cycle that cpu_ack is high, so there is at least one idle CPU cycle between transactions.
- cpu_req dropped before ack: protocol violation; behaviour undefined. The bench asserts on it.

Starvation:
- Wait counter increments each cycle that cpu_req = 1 and no grant occurs. Saturates at MAX_WAIT.
- Clears on grant.
- cpu_starve = (counter == MAX_WAIT), registered.

Simultaneous events:
- disp_req and a pending CPU request in the same cycle: display wins and the CPU waits.
- A CPU read in flight plus a new disp_req: both complete, tags keep them separate.

Address width: addresses pass through unmodified. No wrap logic is needed because the full AW range is backed by RAM.

Test Plan:
1. Reset, then disp_req at 0x0005 with RAM[5] = 0x41 -> disp_valid exactly 2 cycles later, disp_data = 0x41. mem_we stays 0.
2. CPU write 0x0100 <- 0x5A, no display traffic -> mem_we high for one cycle with mem_wdata = 0x5A, cpu_ack 1 cycle after grant. A following CPU read of 0x0100 acks 2 cycles after its grant with cpu_rdata = 0x5A.
3. disp_req held high 80 cycles while cpu_req is pending, MAX_WAIT = 64 -> no CPU grant; cpu_starve rises after 64 waiting cycles. After disp_req drops, CPU is granted next cycle, acked, and cpu_starve clears.
4. CPU read of 0x0200 granted, disp_req for 0x0300 in the next cycle -> cpu_rdata = RAM[0x200] at grant+2, disp_data = RAM[0x300] at grant+3. No cross-delivery.
5. font_wp = 1, CPU write 0x1010 <- 0xFF -> ack at grant+1, mem_we never asserted, RAM[0x1010] unchanged. Repeat with font_wp = 0 -> RAM[0x1010] = 0xFF.
6. Assert reset one cycle after a CPU read grant -> all outputs 0 immediately. No cpu_ack after reset release; the next request completes normally.

Source files
------------

// File: rtl/vram_arbiter.sv
// Video RAM arbiter: the display fetch port always wins and has a fixed 2-cycle latency.
// The CPU port uses a req/ack handshake with optional write protection of the font region.
module vram_arbiter #(
    parameter int          AW        = 13,
    parameter logic [12:0] FONT_BASE = 13'h1000,
    parameter int          MAX_WAIT  = 64
) (
    input  logic          clock_25,
    input  logic          reset,
    input  logic          disp_req,
    input  logic [AW-1:0] disp_addr,
    output logic [7:0]    disp_data,
    output logic          disp_valid,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_wdata,
    output logic [7:0]    cpu_rdata,
    output logic          cpu_ack,
    input  logic          font_wp,
    output logic          cpu_starve,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        SRC_DISP   = 2'd0,
        SRC_CPU_RD = 2'd1,
        SRC_CPU_WR = 2'd2
    } src_t;

    logic          t1_valid_reg, t2_valid_reg;
    src_t          t1_src_reg, t2_src_reg;
    logic          cpu_busy_reg;
    logic [CW-1:0] wait_cnt_reg;

    logic          cpu_grant;
    logic          wp_hit;
    logic          t1_valid_next;
    src_t          t1_src_next;
    logic          cpu_ack_next;
    logic          cpu_busy_next;
    logic [CW-1:0] wait_cnt_next;

    always_comb begin
        cpu_grant     = 1'b0;
        wp_hit        = 1'b0;
        t1_valid_next = 1'b0;
        t1_src_next   = SRC_DISP;
        cpu_ack_next  = 1'b0;
        cpu_busy_next = cpu_busy_reg;
        wait_cnt_next = wait_cnt_reg;

        // The ack cycle is never a grant cycle, so back-to-back CPU requests see one idle cycle.
        cpu_grant = !disp_req && cpu_req && !cpu_busy_reg && !cpu_ack;
        wp_hit    = font_wp && (cpu_addr >= AW'(FONT_BASE));

        if (disp_req) begin
            t1_valid_next = 1'b1;
            t1_src_next   = SRC_DISP;
        end else if (cpu_grant) begin
            t1_valid_next = 1'b1;
            t1_src_next   = cpu_we ? SRC_CPU_WR : SRC_CPU_RD;
        end

        // Writes complete one stage earlier than reads: no data to return.
        cpu_ack_next = (t1_valid_reg && (t1_src_reg == SRC_CPU_WR)) ||
                       (t2_valid_reg && (t2_src_reg == SRC_CPU_RD));

        if (cpu_grant) begin
            cpu_busy_next = 1'b1;
        end else if (cpu_ack_next) begin
            cpu_busy_next = 1'b0;
        end

        if (cpu_grant) begin
            wait_cnt_next = '0;
        end else if (cpu_req && !cpu_busy_reg && !cpu_ack && (wait_cnt_reg != CW'(MAX_WAIT))) begin
            wait_cnt_next = wait_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clock_25 or posedge reset) begin
        if (reset) begin
            t1_valid_reg <= 1'b0;
            t2_valid_reg <= 1'b0;
            t1_src_reg   <= SRC_DISP;
            t2_src_reg   <= SRC_DISP;
            cpu_busy_reg <= 1'b0;
            wait_cnt_reg <= '0;
            cpu_starve   <= 1'b0;
            cpu_ack      <= 1'b0;
            cpu_rdata    <= '0;
            disp_valid   <= 1'b0;
            disp_data    <= '0;
            mem_addr     <= '0;
            mem_we       <= 1'b0;
            mem_wdata    <= '0;
        end else begin
            t1_valid_reg <= t1_valid_next;
            t1_src_reg   <= t1_src_next;
            t2_valid_reg <= t1_valid_reg;
            t2_src_reg   <= t1_src_reg;
            cpu_busy_reg <= cpu_busy_next;
            wait_cnt_reg <= wait_cnt_next;
            cpu_starve   <= (wait_cnt_next == CW'(MAX_WAIT));
            cpu_ack      <= cpu_ack_next;

            if (t2_valid_reg && (t2_src_reg == SRC_CPU_RD)) begin
                cpu_rdata <= mem_rdata;
            end

            disp_valid <= t2_valid_reg && (t2_src_reg == SRC_DISP);
            if (t2_valid_reg && (t2_src_reg == SRC_DISP)) begin
                disp_data <= mem_rdata;
            end

            if (disp_req) begin
                mem_addr <= disp_addr;
            end else if (cpu_grant) begin
                mem_addr <= cpu_addr;
            end

            // A protected write still occupies its slot; only the strobe is suppressed.
            mem_we <= cpu_grant && cpu_we && !wp_hit;
            if (cpu_grant && cpu_we) begin
                mem_wdata <= cpu_wdata;
            end
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural RAM and a queue-based scoreboard
// checking both the returned data and the exact cycle of every strobe.
module tb_vram_arbiter;

    logic        clock_25 = 1'b0;
    logic        reset = 1'b1;
    logic        disp_req = 1'b0;
    logic [12:0] disp_addr = '0;
    logic [7:0]  disp_data;
    logic        disp_valid;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [12:0] cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic [7:0]  cpu_rdata;
    logic        cpu_ack;
    logic        font_wp = 1'b0;
    logic        cpu_starve;
    logic [12:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    vram_arbiter dut (
        .clock_25  (clock_25),
        .reset     (reset),
        .disp_req  (disp_req),
        .disp_addr (disp_addr),
        .disp_data (disp_data),
        .disp_valid(disp_valid),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ack   (cpu_ack),
        .font_wp   (font_wp),
        .cpu_starve(cpu_starve),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #20 clock_25 = ~clock_25;

    // Behavioural RAM with a bench-side preload port.
    logic [7:0]  ram [0:8191];
    logic        pre_we = 1'b0;
    logic [12:0] pre_addr = '0;
    logic [7:0]  pre_data = '0;
    always @(posedge clock_25) begin
        if (pre_we) ram[pre_addr] <= pre_data;
        else if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    int cyc = 0;
    always @(posedge clock_25) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [7:0] data;
        logic       rd;
        int         at;
    } exp_t;
    exp_t disp_q[$];
    exp_t cpu_q[$];

    int          we_count = 0;
    logic [12:0] last_waddr = '0;
    logic [7:0]  last_wdata = '0;

    // Monitor: pops an expectation whenever a strobe appears.
    always @(negedge clock_25) begin
        exp_t e;
        if (mem_we) begin
            we_count++;
            last_waddr = mem_addr;
            last_wdata = mem_wdata;
        end
        if (disp_valid) begin
            total++;
            if (disp_q.size() == 0) begin
                bad++;
                $display("FAIL disp_unexpected cyc=%0d data=%02h required=no strobe", cyc, disp_data);
            end else begin
                e = disp_q.pop_front();
                if (disp_data !== e.data || cyc != e.at) begin
                    bad++;
                    $display("FAIL disp_data got %02h@%0d required %02h@%0d", disp_data, cyc, e.data, e.at);
                end else $display("disp  ok  data=%02h cyc=%0d", disp_data, cyc);
            end
        end
        if (cpu_ack) begin
            total++;
            if (cpu_q.size() == 0) begin
                bad++;
                $display("FAIL cpu_ack_unexpected cyc=%0d rdata=%02h required=no ack", cyc, cpu_rdata);
            end else begin
                e = cpu_q.pop_front();
                if ((e.rd && cpu_rdata !== e.data) || cyc != e.at) begin
                    bad++;
                    $display("FAIL cpu_ack got %02h@%0d required %02h@%0d", cpu_rdata, cyc, e.data, e.at);
                end else $display("cpu   ok  rd=%0b rdata=%02h cyc=%0d", e.rd, cpu_rdata, cyc);
            end
        end
    end

    assert property (@(posedge clock_25) disable iff (reset) $fell(cpu_req) |-> cpu_ack)
        else $error("protocol: cpu_req dropped before cpu_ack");

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clock_25);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s got=%0h required=%0h", name, got, req);
        end else $display("check ok  %s = %0h", name, got);
    endtask

    task automatic preload(input logic [12:0] a, input logic [7:0] d);
        tick();
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        tick();
        pre_we = 1'b0;
    endtask

    task automatic wait_ack(input string name);
        int n = 0;
        while (!cpu_ack && n < 200) begin
            tick();
            n++;
        end
        if (!cpu_ack) begin
            total++;
            bad++;
            $display("FAIL %s_timeout got=no ack required=ack", name);
        end
        cpu_req = 1'b0;
    endtask

    // Request issued with no display traffic: granted on the next edge.
    task automatic cpu_op(input string name, input logic we, input logic [12:0] a,
                          input logic [7:0] wd, input logic [7:0] exp_rd);
        exp_t e;
        tick();
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
        e.data = exp_rd; e.rd = !we; e.at = cyc + (we ? 2 : 3);
        cpu_q.push_back(e);
        tick();
        wait_ack(name);
    endtask

    task automatic disp_one(input logic [12:0] a, input logic [7:0] d);
        exp_t e;
        disp_req = 1'b1; disp_addr = a;
        e.data = d; e.rd = 1'b1; e.at = cyc + 3;
        disp_q.push_back(e);
    endtask

    initial begin
        int w0;
        exp_t e;
        tick(2);
        check("reset_outputs", {mem_addr, mem_we, mem_wdata, disp_data, disp_valid,
                                cpu_rdata, cpu_ack, cpu_starve}, 32'h0);
        preload(13'h0005, 8'h41);
        preload(13'h0100, 8'h00);
        preload(13'h0200, 8'h77);
        preload(13'h0300, 8'h3C);
        preload(13'h1010, 8'h11);
        tick();
        reset = 1'b0;
        tick(2);

        // 1: single display read
        w0 = we_count;
        disp_one(13'h0005, 8'h41);
        tick();
        disp_req = 1'b0;
        tick(4);
        check("t1_no_write", we_count - w0, 0);

        // 2: write then read back
        w0 = we_count;
        cpu_op("t2_write", 1'b1, 13'h0100, 8'h5A, 8'h00);
        tick(2);
        check("t2_we_pulses", we_count - w0, 1);
        check("t2_waddr", last_waddr, 13'h0100);
        check("t2_wdata", last_wdata, 8'h5A);
        cpu_op("t2_read", 1'b0, 13'h0100, 8'h00, 8'h5A);
        tick(3);

        // 3: display holds the RAM for 80 cycles while the CPU waits
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0005;
        for (int k = 1; k <= 80; k++) begin
            disp_one(13'h0005, 8'h41);
            tick();
            if (k == 30) check("t3_starve_k30", cpu_starve, 1'b0);
            if (k == 63) check("t3_starve_k63", cpu_starve, 1'b0);
            if (k == 64) check("t3_starve_k64", cpu_starve, 1'b1);
        end
        check("t3_starve_k80", cpu_starve, 1'b1);
        disp_req = 1'b0;
        e.data = 8'h41; e.rd = 1'b1; e.at = cyc + 3;
        cpu_q.push_back(e);
        tick();
        wait_ack("t3_read");
        check("t3_starve_cleared", cpu_starve, 1'b0);
        tick(3);

        // 4: CPU read in flight, display read one cycle later
        tick();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0200;
        e.data = 8'h77; e.rd = 1'b1; e.at = cyc + 3;
        cpu_q.push_back(e);
        tick();
        disp_one(13'h0300, 8'h3C);
        tick();
        disp_req = 1'b0;
        wait_ack("t4_read");
        tick(4);

        // 5: protected font write, then unprotected
        font_wp = 1'b1;
        w0 = we_count;
        cpu_op("t5_wp_write", 1'b1, 13'h1010, 8'hFF, 8'h00);
        tick(3);
        check("t5_wp_no_we", we_count - w0, 0);
        check("t5_wp_ram", ram[13'h1010], 8'h11);
        font_wp = 1'b0;
        cpu_op("t5_write", 1'b1, 13'h1010, 8'hFF, 8'h00);
        tick(3);
        check("t5_we_pulses", we_count - w0, 1);
        check("t5_ram", ram[13'h1010], 8'hFF);

        // 6: reset arrives while a CPU read is in flight
        tick();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0005;
        tick();
        check("t6_granted_addr", mem_addr, 13'h0005);
        reset = 1'b1;
        #1;
        check("t6_reset_outputs", {mem_addr, mem_we, mem_wdata, disp_data, disp_valid,
                                   cpu_rdata, cpu_ack, cpu_starve}, 32'h0);
        cpu_req = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(6);
        check("t6_no_stale_ack", cpu_q.size(), 0);
        cpu_op("t6_read", 1'b0, 13'h0005, 8'h00, 8'h41);
        tick(4);

        check("end_disp_queue_empty", disp_q.size(), 0);
        check("end_cpu_queue_empty", cpu_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
